// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 4-bit controller: op codes, command
// bytes, DDRAM row offsets and the time-to-cycles conversion.
package lcd_pkg;

  typedef enum logic [1:0] {
    OP_WRITE  = 2'd0,
    OP_CMD    = 2'd1,
    OP_SETCUR = 2'd2,
    OP_CLEAR  = 2'd3
  } op_e;

  localparam logic [7:0] CMD_CLEAR   = 8'h01;
  localparam logic [7:0] CMD_HOME    = 8'h02;
  localparam logic [7:0] CMD_ENTRY   = 8'h06;
  localparam logic [7:0] CMD_DISP_ON = 8'h0C;
  localparam logic [7:0] CMD_FUNC_1L = 8'h20;
  localparam logic [7:0] CMD_FUNC_2L = 8'h28;
  localparam logic [7:0] CMD_DDRAM   = 8'h80;

  // Element r is the DDRAM start address of display row r.
  localparam logic [3:0][6:0] ROW_OFFSET = {7'h54, 7'h14, 7'h40, 7'h00};

  localparam longint T40M_US   = 40000;
  localparam longint T5M_US    = 5000;
  localparam longint T1M_US    = 1000;
  localparam longint TLONG_US  = 2000;
  localparam longint TSHORT_US = 40;
  localparam longint EN_US     = 1;

  function automatic int delay_cycles(longint rate_hz, longint t_us);
    longint c;
    c = (rate_hz * t_us + 64'd999_999) / 64'd1_000_000;
    return (c < 1) ? 1 : int'(c);
  endfunction

endpackage

// File: rtl/lcd_nibble_tx.sv
// Sends one byte as two nibbles (or a single high nibble) with setup/enable/hold
// framing, followed by the post-command settle gap for full bytes.
module lcd_nibble_tx
  import lcd_pkg::*;
#(
  parameter int CLOCK_RATE = 1000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic       nib_i,
  input  logic       long_i,
  input  logic       rs_i,
  input  logic [7:0] byte_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       en_o,
  output logic       rs_o,
  output logic [3:0] data_o
);

  localparam int EN_CYC  = delay_cycles(CLOCK_RATE, EN_US);
  localparam int TLONG   = delay_cycles(CLOCK_RATE, TLONG_US);
  localparam int TSHORT  = delay_cycles(CLOCK_RATE, TSHORT_US);
  localparam int CNT_MAX = (EN_CYC > TLONG) ? EN_CYC : TLONG;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {TX_IDLE, TX_SETUP, TX_EN, TX_HOLD, TX_GAP} tx_state_e;

  tx_state_e       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      byte_q, byte_d;
  logic            rs_q, rs_d, long_q, long_d, nib_q, nib_d, lo_q, lo_d;
  logic            en_q;
  logic            done;
  logic [CW-1:0]   gap_last;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= TX_IDLE;
      cnt_q   <= '0;
      byte_q  <= '0;
      rs_q    <= 1'b0;
      long_q  <= 1'b0;
      nib_q   <= 1'b0;
      lo_q    <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      byte_q  <= byte_d;
      rs_q    <= rs_d;
      long_q  <= long_d;
      nib_q   <= nib_d;
      lo_q    <= lo_d;
      en_q    <= (state_d == TX_EN);
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    byte_d   = byte_q;
    rs_d     = rs_q;
    long_d   = long_q;
    nib_d    = nib_q;
    lo_d     = lo_q;
    gap_last = long_q ? CW'(TLONG - 1) : CW'(TSHORT - 1);
    done     = ((state_q == TX_HOLD) && nib_q) ||
               ((state_q == TX_GAP) && (cnt_q == gap_last));
    // A new request may start in the final cycle of the previous one, so
    // back-to-back transfers have no dead cycle between them.
    if (start_i && ((state_q == TX_IDLE) || done)) begin
      state_d = TX_SETUP;
      cnt_d   = '0;
      byte_d  = byte_i;
      rs_d    = rs_i;
      long_d  = long_i;
      nib_d   = nib_i;
      lo_d    = 1'b0;
    end else begin
      case (state_q)
        TX_SETUP: begin
          state_d = TX_EN;
          cnt_d   = '0;
        end
        TX_EN: begin
          if (cnt_q == CW'(EN_CYC - 1)) state_d = TX_HOLD;
          else                          cnt_d   = cnt_q + 1'b1;
        end
        TX_HOLD: begin
          if (nib_q) begin
            state_d = TX_IDLE;
          end else if (!lo_q) begin
            state_d = TX_SETUP;
            lo_d    = 1'b1;
          end else begin
            state_d = TX_GAP;
            cnt_d   = '0;
          end
        end
        TX_GAP: begin
          if (cnt_q == gap_last) state_d = TX_IDLE;
          else                   cnt_d   = cnt_q + 1'b1;
        end
        default: state_d = TX_IDLE;
      endcase
    end
  end

  assign busy_o = (state_q != TX_IDLE);
  assign done_o = done;
  assign en_o   = en_q;
  assign rs_o   = busy_o & rs_q;
  assign data_o = busy_o ? (lo_q ? byte_q[3:0] : byte_q[7:4]) : 4'h0;

endmodule

// File: rtl/lcd_ctrl.sv
// HD44780 4-bit controller: power-on init sequence, then a request interface
// for chars, raw commands, cursor placement and clear with cursor tracking.
module lcd_ctrl
  import lcd_pkg::*;
#(
  parameter int CLOCK_RATE = 1000,
  parameter int ROWS       = 2,
  parameter int COLS       = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] in_op,
  input  logic [7:0] in_data,
  output logic       en,
  output logic       rs,
  output logic [3:0] data,
  output logic       init_done
);

  localparam int T40M   = delay_cycles(CLOCK_RATE, T40M_US);
  localparam int T5M    = delay_cycles(CLOCK_RATE, T5M_US);
  localparam int T1M    = delay_cycles(CLOCK_RATE, T1M_US);
  localparam int TSHORT = delay_cycles(CLOCK_RATE, TSHORT_US);
  localparam int CW     = $clog2(T40M + 1);
  localparam logic [1:0] ROW_MAX = 2'(ROWS - 1);
  localparam logic [5:0] COL_MAX = 6'(COLS - 1);
  localparam logic [7:0] CMD_FUNC = (ROWS == 1) ? CMD_FUNC_1L : CMD_FUNC_2L;

  typedef enum logic [2:0] {RESET_WAIT, INIT, IDLE, SEND, ADDR_FIX, WAIT} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, init_dly;
  logic [3:0]    step_q, step_d;
  logic [1:0]    row_q, row_d, set_row;
  logic [5:0]    col_q, col_d, set_col;
  logic          wrap_q, wrap_d, init_done_q, init_done_d;
  logic [7:0]    data_q, data_d, init_byte, char_byte;
  logic          init_nib, init_long, issue_init, send_char;
  logic          tx_start, tx_nib, tx_long, tx_rs, tx_busy, tx_done;
  logic [7:0]    tx_byte;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= RESET_WAIT;
      cnt_q       <= '0;
      step_q      <= '0;
      row_q       <= '0;
      col_q       <= '0;
      wrap_q      <= 1'b0;
      data_q      <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      step_q      <= step_d;
      row_q       <= row_d;
      col_q       <= col_d;
      wrap_q      <= wrap_d;
      data_q      <= data_d;
      init_done_q <= init_done_d;
    end
  end

  // Init script: three 0x3 nibbles, one 0x2 nibble, then four full commands.
  always_comb begin
    init_nib  = (step_q < 4'd4);
    init_long = 1'b0;
    case (step_q)
      4'd0, 4'd1, 4'd2: init_byte = 8'h30;
      4'd3:             init_byte = 8'h20;
      4'd4:             init_byte = CMD_FUNC;
      4'd5:             init_byte = CMD_DISP_ON;
      4'd6:             init_byte = CMD_ENTRY;
      default: begin
        init_byte = CMD_CLEAR;
        init_long = 1'b1;
      end
    endcase
    case (step_q)
      4'd1, 4'd2: init_dly = CW'(T5M - 1);
      4'd3:       init_dly = CW'(T1M - 1);
      default:    init_dly = CW'(TSHORT - 1);
    endcase
  end

  assign set_row   = (in_data[7:6] > ROW_MAX) ? ROW_MAX : in_data[7:6];
  assign set_col   = (in_data[5:0] > COL_MAX) ? COL_MAX : in_data[5:0];
  assign char_byte = (state_q == IDLE) ? in_data : data_q;
  assign in_ready  = (state_q == IDLE) && !tx_busy;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    step_d      = step_q;
    row_d       = row_q;
    col_d       = col_q;
    wrap_d      = wrap_q;
    data_d      = data_q;
    init_done_d = init_done_q;
    tx_start    = 1'b0;
    tx_nib      = 1'b0;
    tx_long     = 1'b0;
    tx_rs       = 1'b0;
    tx_byte     = 8'h00;
    issue_init  = 1'b0;
    send_char   = 1'b0;
    case (state_q)
      RESET_WAIT: begin
        if (cnt_q == CW'(T40M - 1)) issue_init = 1'b1;
        else                        cnt_d      = cnt_q + 1'b1;
      end
      INIT: begin
        if (tx_done) begin
          if (step_q == 4'd8) begin
            state_d     = IDLE;
            init_done_d = 1'b1;
          end else if (step_q <= 4'd4) begin
            state_d = WAIT;
            cnt_d   = '0;
          end else begin
            issue_init = 1'b1;
          end
        end
      end
      WAIT: begin
        if (cnt_q == init_dly) issue_init = 1'b1;
        else                   cnt_d      = cnt_q + 1'b1;
      end
      IDLE: begin
        if (in_valid && in_ready) begin
          data_d = in_data;
          case (op_e'(in_op))
            OP_WRITE: begin
              // After a line wrap the LCD's own address is out of step with
              // the tracker, so reposition before the char goes out.
              if (wrap_q) begin
                tx_start = 1'b1;
                tx_byte  = CMD_DDRAM | {1'b0, ROW_OFFSET[row_q]};
                wrap_d   = 1'b0;
                state_d  = ADDR_FIX;
              end else begin
                send_char = 1'b1;
              end
            end
            OP_CMD: begin
              tx_start = 1'b1;
              tx_byte  = in_data;
              tx_long  = (in_data == CMD_CLEAR) || (in_data == CMD_HOME);
              state_d  = SEND;
              if (tx_long) begin
                row_d  = '0;
                col_d  = '0;
                wrap_d = 1'b0;
              end
            end
            OP_SETCUR: begin
              tx_start = 1'b1;
              tx_byte  = CMD_DDRAM | {1'b0, ROW_OFFSET[set_row] + {1'b0, set_col}};
              row_d    = set_row;
              col_d    = set_col;
              wrap_d   = 1'b0;
              state_d  = SEND;
            end
            OP_CLEAR: begin
              tx_start = 1'b1;
              tx_byte  = CMD_CLEAR;
              tx_long  = 1'b1;
              row_d    = '0;
              col_d    = '0;
              wrap_d   = 1'b0;
              state_d  = SEND;
            end
          endcase
        end
      end
      ADDR_FIX: if (tx_done) send_char = 1'b1;
      SEND:     if (tx_done) state_d = IDLE;
      default:  state_d = IDLE;
    endcase

    if (issue_init) begin
      tx_start = 1'b1;
      tx_byte  = init_byte;
      tx_nib   = init_nib;
      tx_long  = init_long;
      step_d   = step_q + 4'd1;
      state_d  = INIT;
    end

    if (send_char) begin
      tx_start = 1'b1;
      tx_rs    = 1'b1;
      tx_byte  = char_byte;
      state_d  = SEND;
      if (col_q == COL_MAX) begin
        col_d  = '0;
        row_d  = (row_q == ROW_MAX) ? 2'd0 : row_q + 2'd1;
        wrap_d = 1'b1;
      end else begin
        col_d = col_q + 6'd1;
      end
    end
  end

  assign init_done = init_done_q;

  lcd_nibble_tx #(
    .CLOCK_RATE(CLOCK_RATE)
  ) u_tx (
    .clk_i  (clk),
    .rst_ni (reset),
    .start_i(tx_start),
    .nib_i  (tx_nib),
    .long_i (tx_long),
    .rs_i   (tx_rs),
    .byte_i (tx_byte),
    .busy_o (tx_busy),
    .done_o (tx_done),
    .en_o   (en),
    .rs_o   (rs),
    .data_o (data)
  );

endmodule

// File: tb/tb_lcd_ctrl.sv
// Directed bench for lcd_ctrl at 1 kHz, 2x16: init timing and nibble stream,
// chars, wraps, cursor placement, clear, raw commands and mid-op reset.
module tb_lcd_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [1:0] in_op = 2'd0;
  logic [7:0] in_data = 8'h00;
  logic       en, rs;
  logic [3:0] data;
  logic       init_done;

  int n_tests = 0;
  int n_fail  = 0;

  logic [4:0] cap[$];
  logic       en_prev = 1'b0;
  logic [4:0] exp_init [12];

  always #5 clk = ~clk;

  lcd_ctrl #(.CLOCK_RATE(1000), .ROWS(2), .COLS(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_data(in_data), .en(en), .rs(rs), .data(data),
    .init_done(init_done)
  );

  // Record {rs, data} at every rising edge of en.
  always @(negedge clk) begin
    if (en && !en_prev) cap.push_back({rs, data});
    en_prev <= en;
  end

  // Drive one request when in_ready allows; low = cycles in_ready stayed low.
  task automatic send_op(input logic [1:0] op, input logic [7:0] d, output int low);
    int w;
    w   = 0;
    low = -1;
    while (!in_ready && w < 200) begin @(posedge clk); #1; w++; end
    if (!in_ready) return;
    cap.delete();
    @(negedge clk);
    in_valid = 1'b1; in_op = op; in_data = d;
    @(posedge clk); #1;
    in_valid = 1'b0; in_op = 2'($urandom); in_data = 8'($urandom);
    low = 0;
    while (!in_ready && low < 200) begin low++; @(posedge clk); #1; end
  endtask

  task automatic test_init_seq(input string tag);
    int n;
    @(negedge clk);
    cap.delete();
    reset = 1'b1;
    n = 0;
    while (!init_done && n < 300) begin @(posedge clk); #1; n++; end
    n_tests++;
    if (n !== 93) begin n_fail++; $display("FAIL %s_init_cycles: got %0d want 93", tag, n); end
    n_tests++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL %s_ready: got %b want 1", tag, in_ready); end
    n_tests++;
    if (cap.size() != 12) begin
      n_fail++; $display("FAIL %s_nibble_count: got %0d want 12", tag, cap.size());
    end else begin
      for (int i = 0; i < 12; i++) begin
        n_tests++;
        if (cap[i] !== exp_init[i]) begin
          n_fail++; $display("FAIL %s_nibble%0d: got %h want %h", tag, i, cap[i], exp_init[i]);
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (en !== 1'b0)        begin n_fail++; $display("FAIL rst_en: got %b want 0", en); end
    n_tests++; if (rs !== 1'b0)        begin n_fail++; $display("FAIL rst_rs: got %b want 0", rs); end
    n_tests++; if (data !== 4'h0)      begin n_fail++; $display("FAIL rst_data: got %h want 0", data); end
    n_tests++; if (in_ready !== 1'b0)  begin n_fail++; $display("FAIL rst_ready: got %b want 0", in_ready); end
    n_tests++; if (init_done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", init_done); end
    test_init_seq("por");
  endtask

  task automatic test_write_char();
    int low;
    send_op(2'd0, 8'h41, low);
    n_tests++; if (low !== 7) begin n_fail++; $display("FAIL wr_low: got %0d want 7", low); end
    n_tests++;
    if (cap.size() != 2) begin
      n_fail++; $display("FAIL wr_count: got %0d want 2", cap.size());
    end else begin
      n_tests++; if (cap[0] !== 5'h14) begin n_fail++; $display("FAIL wr_hi: got %h want 14", cap[0]); end
      n_tests++; if (cap[1] !== 5'h11) begin n_fail++; $display("FAIL wr_lo: got %h want 11", cap[1]); end
    end
  endtask

  task automatic test_raw();
    logic [7:0] cmds [2];
    int         lows [2];
    int         low;
    cmds = '{8'h0C, 8'h02};
    lows = '{7, 8};
    for (int k = 0; k < 2; k++) begin
      send_op(2'd1, cmds[k], low);
      n_tests++;
      if (low !== lows[k]) begin n_fail++; $display("FAIL raw%0d_low: got %0d want %0d", k, low, lows[k]); end
      n_tests++;
      if (cap.size() != 2) begin
        n_fail++; $display("FAIL raw%0d_count: got %0d want 2", k, cap.size());
      end else begin
        n_tests++;
        if ({cap[0], cap[1]} !== {1'b0, cmds[k][7:4], 1'b0, cmds[k][3:0]}) begin
          n_fail++; $display("FAIL raw%0d_nibbles: got %h,%h want %h", k, cap[0], cap[1], cmds[k]);
        end
      end
    end
  endtask

  // 33 chars from (0,0): row-1 address before char 17, row-0 address before char 33.
  task automatic test_wrap();
    logic [7:0] ch, addr;
    logic [4:0] ev [$];
    int         low, want_low;
    for (int i = 1; i <= 33; i++) begin
      ch   = 8'h30 + 8'(i);
      addr = (i == 17) ? 8'hC0 : 8'h80;
      ev.delete();
      if (i == 17 || i == 33) begin
        ev.push_back({1'b0, addr[7:4]});
        ev.push_back({1'b0, addr[3:0]});
      end
      ev.push_back({1'b1, ch[7:4]});
      ev.push_back({1'b1, ch[3:0]});
      want_low = (ev.size() == 4) ? 14 : 7;
      send_op(2'd0, ch, low);
      n_tests++;
      if (low !== want_low) begin n_fail++; $display("FAIL wrap%0d_low: got %0d want %0d", i, low, want_low); end
      n_tests++;
      if (cap.size() != ev.size()) begin
        n_fail++; $display("FAIL wrap%0d_count: got %0d want %0d", i, cap.size(), ev.size());
      end else begin
        for (int j = 0; j < ev.size(); j++) begin
          n_tests++;
          if (cap[j] !== ev[j]) begin
            n_fail++; $display("FAIL wrap%0d_n%0d: got %h want %h", i, j, cap[j], ev[j]);
          end
        end
      end
    end
  endtask

  task automatic test_set_cursor();
    int low;
    send_op(2'd2, {2'd3, 6'd50}, low);
    n_tests++; if (low !== 7) begin n_fail++; $display("FAIL setcur_low: got %0d want 7", low); end
    n_tests++;
    if (cap.size() != 2) begin
      n_fail++; $display("FAIL setcur_count: got %0d want 2", cap.size());
    end else begin
      n_tests++;
      if ({cap[0], cap[1]} !== {5'h0C, 5'h0F}) begin
        n_fail++; $display("FAIL setcur_cmd: got %h,%h want 0C,0F", cap[0], cap[1]);
      end
    end
    // Char at (1,15): no address first, then the cursor wraps to (0,0).
    send_op(2'd0, 8'h5A, low);
    n_tests++; if (low !== 7) begin n_fail++; $display("FAIL setcur_char_low: got %0d want 7", low); end
    n_tests++;
    if (cap.size() != 2) begin
      n_fail++; $display("FAIL setcur_char_count: got %0d want 2", cap.size());
    end
  endtask

  task automatic test_clear();
    int low;
    send_op(2'd3, 8'h00, low);
    n_tests++; if (low !== 8) begin n_fail++; $display("FAIL clr_low: got %0d want 8", low); end
    n_tests++;
    if (cap.size() != 2) begin
      n_fail++; $display("FAIL clr_count: got %0d want 2", cap.size());
    end else begin
      n_tests++;
      if ({cap[0], cap[1]} !== {5'h00, 5'h01}) begin
        n_fail++; $display("FAIL clr_cmd: got %h,%h want 00,01", cap[0], cap[1]);
      end
    end
    send_op(2'd0, 8'h42, low);
    n_tests++; if (low !== 7) begin n_fail++; $display("FAIL clr_char_low: got %0d want 7", low); end
    n_tests++;
    if (cap.size() != 2) begin
      n_fail++; $display("FAIL clr_char_count: got %0d want 2", cap.size());
    end else begin
      n_tests++;
      if ({cap[0], cap[1]} !== {5'h14, 5'h12}) begin
        n_fail++; $display("FAIL clr_char: got %h,%h want 14,12", cap[0], cap[1]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int w;
    w = 0;
    while (!in_ready && w < 200) begin @(posedge clk); #1; w++; end
    @(negedge clk);
    in_valid = 1'b1; in_op = 2'd0; in_data = 8'h41;
    @(posedge clk); #1;
    in_valid = 1'b0;
    w = 0;
    while (!en && w < 20) begin @(posedge clk); #1; w++; end
    n_tests++; if (en !== 1'b1) begin n_fail++; $display("FAIL mid_en_seen: got %b want 1", en); end
    reset = 1'b0;
    #1;
    n_tests++; if (en !== 1'b0)        begin n_fail++; $display("FAIL mid_en: got %b want 0", en); end
    n_tests++; if (in_ready !== 1'b0)  begin n_fail++; $display("FAIL mid_ready: got %b want 0", in_ready); end
    n_tests++; if (init_done !== 1'b0) begin n_fail++; $display("FAIL mid_done: got %b want 0", init_done); end
    repeat (2) @(posedge clk);
    test_init_seq("rerun");
  endtask

  initial begin
    exp_init = '{5'h03, 5'h03, 5'h03, 5'h02, 5'h02, 5'h08,
                 5'h00, 5'h0C, 5'h00, 5'h06, 5'h00, 5'h01};
    test_reset();
    test_write_char();
    test_raw();
    test_wrap();
    test_set_cursor();
    test_clear();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
